// File: rtl/tpu_pkg.sv
// Shared types and defaults for the tiled matrix-multiply scheduler.
package tpu_pkg;

    localparam int unsigned NTilesDefault  = 2;
    localparam int unsigned TimeoutDefault = 15;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StWb
    } sched_state_e;

    // A single tile still needs a one-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_index_counter.sv
// Nested (row, col, k) tile counter: k innermost, then col, then row.
module tile_index_counter import tpu_pkg::*; #(
    parameter int unsigned N_TILES = NTilesDefault,
    localparam int unsigned IW     = idx_width(N_TILES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_k_i,
    input  logic          next_tile_i,
    output logic [IW-1:0] row_o,
    output logic [IW-1:0] col_o,
    output logic [IW-1:0] k_o,
    output logic          last_k_o,
    output logic          last_tile_o
);

    localparam logic [IW-1:0] Last = IW'(N_TILES - 1);

    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;
    logic [IW-1:0] k_q, k_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        k_d   = k_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
            k_d   = '0;
        end else if (next_tile_i) begin
            k_d = '0;
            if (col_q == Last) begin
                col_d = '0;
                row_d = (row_q == Last) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (inc_k_i) begin
            k_d = (k_q == Last) ? '0 : k_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            k_q   <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            k_q   <= k_d;
        end
    end

    assign row_o       = row_q;
    assign col_o       = col_q;
    assign k_o         = k_q;
    assign last_k_o    = (k_q == Last);
    assign last_tile_o = (row_q == Last) && (col_q == Last);

endmodule

// File: rtl/matmul_tile_sched.sv
// Issues row-major tile jobs to a 2x2 MMU, waits for completion with a timeout,
// and hands each finished output tile to the writeback side.
module matmul_tile_sched import tpu_pkg::*; #(
    parameter int unsigned N_TILES = NTilesDefault,
    parameter int unsigned TIMEOUT = TimeoutDefault,
    localparam int unsigned IW     = idx_width(N_TILES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          job_valid_o,
    input  logic          job_ready_i,
    output logic [IW-1:0] job_row_o,
    output logic [IW-1:0] job_col_o,
    output logic [IW-1:0] job_k_o,
    output logic          job_accum_o,
    input  logic          mmu_done_i,
    output logic          wb_valid_o,
    input  logic          wb_ready_i,
    output logic [IW-1:0] wb_row_o,
    output logic [IW-1:0] wb_col_o,
    output logic [15:0]   cyc_cnt_o
);

    localparam int unsigned    TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

    sched_state_e  state_q;
    logic          done_q;
    logic          err_q;
    logic [TW-1:0] timer_q;
    logic [15:0]   cyc_q;

    logic [IW-1:0] row, col, k;
    logic          last_k, last_tile;
    logic          idx_clr, idx_inc_k, idx_next_tile;

    assign idx_clr       = !abort_i && (state_q == StIdle) && start_i;
    assign idx_inc_k     = !abort_i && (state_q == StWait) && mmu_done_i && !last_k;
    assign idx_next_tile = !abort_i && (state_q == StWb) && wb_ready_i && !last_tile;

    tile_index_counter #(
        .N_TILES (N_TILES)
    ) u_idx (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (idx_clr),
        .inc_k_i     (idx_inc_k),
        .next_tile_i (idx_next_tile),
        .row_o       (row),
        .col_o       (col),
        .k_o         (k),
        .last_k_o    (last_k),
        .last_tile_o (last_tile)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
            cyc_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle && cyc_q != 16'hFFFF) begin
                cyc_q <= cyc_q + 16'd1;
            end
            if (abort_i) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            state_q <= StIssue;
                            err_q   <= 1'b0;
                            cyc_q   <= '0;
                        end
                    end
                    StIssue: begin
                        if (job_ready_i) begin
                            state_q <= StWait;
                            timer_q <= '0;
                        end
                    end
                    StWait: begin
                        // A completion in the timeout cycle still counts as success.
                        if (mmu_done_i) begin
                            state_q <= last_k ? StWb : StIssue;
                        end else if (timer_q == TimerLast) begin
                            state_q <= StIdle;
                            err_q   <= 1'b1;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    StWb: begin
                        if (wb_ready_i) begin
                            if (last_tile) begin
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StIssue;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign job_valid_o = (state_q == StIssue);
    assign job_row_o   = row;
    assign job_col_o   = col;
    assign job_k_o     = k;
    assign job_accum_o = (k != '0);
    assign wb_valid_o  = (state_q == StWb);
    assign wb_row_o    = row;
    assign wb_col_o    = col;
    assign cyc_cnt_o   = cyc_q;

endmodule
